// File: rtl/tdm_demux4_if.sv
// Link interface between the TDM stream source and the 4-channel demultiplexer.
// The master drives the slot strobe, frame marker and data. The slave returns
// the recovered channels and the link status.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);
  logic             EN;
  logic             SYNC;
  logic [WIDTH-1:0] Z;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic             S1;
  logic             S0;
  logic             VALID;
  logic             LOCK;
  logic             SYNC_ERR;

  modport master (
    output EN, SYNC, Z,
    input  A, B, C, D, S1, S0, VALID, LOCK, SYNC_ERR
  );

  modport slave (
    input  EN, SYNC, Z,
    output A, B, C, D, S1, S0, VALID, LOCK, SYNC_ERR
  );
endinterface

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link.
// It finds frame alignment from the SYNC marker and splits the stream into
// four registered channels A..D. Slots 0..2 are held in shadow registers, so
// the outputs change only as a complete frame.
module tdm_demux4 #(
  parameter int WIDTH    = 1,
  parameter int MAX_MISS = 3
) (
  input  logic          CLK,
  input  logic          RST,
  tdm_demux4_if.slave   bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [3:0] MAX_MISS_C = 4'(MAX_MISS);

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [3:0]       miss_q, miss_d;
  logic [3:0]       miss_inc;
  logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, shc_q, shc_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Next-state logic: alignment FSM, slot counter, shadow capture and frame commit.
  // NOTE: every signal gets a default first so that no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    miss_d   = miss_q;
    miss_inc = miss_q + 4'd1;
    sha_d    = sha_q;
    shb_d    = shb_q;
    shc_d    = shc_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (bus.EN) begin
      unique case (state_q)
        HUNT: begin
          if (bus.SYNC) begin
            sha_d   = bus.Z;
            slot_d  = 2'd1;
            miss_d  = 4'd0;
            state_d = LOCKED;
          end
        end

        LOCKED: begin
          if (bus.SYNC && slot_q != 2'd0) begin
            // A marker away from slot 0 drops the partial frame. That sample starts a new frame.
            err_d  = 1'b1;
            sha_d  = bus.Z;
            slot_d = 2'd1;
            miss_d = 4'd0;
          end else begin
            unique case (slot_q)
              2'd0: begin
                if (bus.SYNC) begin
                  sha_d  = bus.Z;
                  miss_d = 4'd0;
                  slot_d = 2'd1;
                end else if (miss_inc == MAX_MISS_C) begin
                  state_d = HUNT;
                  slot_d  = 2'd0;
                  miss_d  = 4'd0;
                end else begin
                  // Flywheel: keep the assumed alignment while the misses stay below the limit.
                  sha_d  = bus.Z;
                  miss_d = miss_inc;
                  slot_d = 2'd1;
                end
              end
              2'd1: begin
                shb_d  = bus.Z;
                slot_d = 2'd2;
              end
              2'd2: begin
                shc_d  = bus.Z;
                slot_d = 2'd3;
              end
              default: begin
                a_d     = sha_q;
                b_d     = shb_q;
                c_d     = shc_q;
                d_d     = bus.Z;
                valid_d = 1'b1;
                slot_d  = 2'd0;
              end
            endcase
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // State register. Synchronous reset has priority over EN and SYNC.
  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      miss_q  <= 4'd0;
      sha_q   <= '0;
      shb_q   <= '0;
      shc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shc_q   <= shc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.C        = c_q;
  assign bus.D        = d_q;
  assign bus.S1       = slot_q[1];
  assign bus.S0       = slot_q[0];
  assign bus.VALID    = valid_q;
  assign bus.LOCK     = (state_q == LOCKED);
  assign bus.SYNC_ERR = err_q;

endmodule
